filter_buffer_5x5: RTL and testbench
====================================

# filter_buffer_5x5

On-chip store for the CNN accelerator's convolution weights. It holds up to 300 signed 16-bit 5×5 filters and a 120-entry bias vector. Both are written by the load controller and read by the convolution datapath through independent index ports. After every accepted write it raises a completion flag so the controller can sequence the next load.

## Interface
Parameters:
- `N`, 5: filter side length; a filter is N×N words.
- `DATA_W`, 16: word width, signed two's complement.
- `FILTER_DEPTH`, 300: number of filter slots.
- `BIAS_DEPTH`, 120: number of bias entries.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `FB_write`  in  1  write strobe.
- `FB_bias_or_filter`  in  1  write target select: 1 = filter store, 0 = bias store.
- `FB_filter`  in  N×N×DATA_W  filter write data, `[row][col]`.
- `FB_index_filter`  in  16  filter write slot.
- `FB_bias`  in  BIAS_DEPTH×DATA_W  full bias vector write data.
- `FB_index_bias`  in  16  bias read index.
- `index_filter`  in  16  filter read slot.
- `filter`  out  N×N×DATA_W  filter read data.
- `FB_output_bias`  out  DATA_W  bias read data.
- `FB_filter_buffer_finish`  out  1  write-complete flag.

## Operation
- Filter write: on a rising edge with `FB_write`=1 and `FB_bias_or_filter`=1, all N×N words of `FB_filter` are stored into slot `FB_index_filter`.
- Bias write: on a rising edge with `FB_write`=1 and `FB_bias_or_filter`=0, all BIAS_DEPTH words of `FB_bias` are stored at once.
- The two stores are independent; a write to one never alters the other.
- Out-of-range index handling:
  - `FB_index_filter` ≥ FILTER_DEPTH or negative: the write is dropped and finish is not raised.
  - `index_filter` out of range: `filter` reads as all zeros.
  - `FB_index_bias` ≥ BIAS_DEPTH or negative: `FB_output_bias` reads as zero.
- Filter read: every edge, `filter` ← store[`index_filter`].
  - Write-first: if the same edge writes that slot, `filter` takes the new `FB_filter` data.
- Bias read: every edge, `FB_output_bias` ← bias[`FB_index_bias`].
  - Write-first: if the same edge performs a bias write, the new `FB_bias` entry is used.
- Finish flag: every edge, `FB_filter_buffer_finish` ← 1 if that edge performed an accepted write (filter or bias), else 0.
  - It stays 1 while writes continue on consecutive edges.
  - It drops to 0 on the first edge without an accepted write.
- No state machine; the block is a register array with registered read ports.

## Timing
- Reset (`reset`=0, asynchronous):
  - all filter slots and bias entries clear to 0;
  - `filter`, `FB_output_bias` and `FB_filter_buffer_finish` are 0 immediately.
- Release is taken synchronously at the next rising edge.
- Write latency: data is stored at the edge where the write is sampled.
- Read latency: one cycle. Read data reflects the index sampled at the previous edge, including a same-edge write.
- Reset asserted mid-write: that write is lost and the flag is 0.
- Index inputs may change every cycle; there is no handshake beyond `FB_write`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles -> `filter` all 0, `FB_output_bias`=0, finish=0; after release, read slot 7 -> all 0.
- Filter sweep: for i=0..299, write a random 5×5 (values 0..99) with `FB_index_filter`=`index_filter`=i for one edge -> next cycle `filter` equals the written array and finish=1. Deassert `FB_write` for one edge -> finish=0.
- Retention: after the sweep, read slots 0, 150, 299 -> each matches its recorded data; slot 300 -> all 0, and a write to slot 300 leaves finish=0.
- Negative data: write -32768 at [0][0] and 32767 at [4][4] of slot 5 -> both read back exactly.
- Bias load: `FB_bias_or_filter`=0, `FB_bias[k]`=k−60, one write edge -> finish=1 and filter slots unchanged; then `FB_index_bias`=0, 119, 120 -> `FB_output_bias`=-60, 59, 0.
- Back-to-back writes with a reset pulse between them: finish stays 1 across consecutive writes, is forced to 0 by the reset, and the slot written before the reset reads 0.

Source files
------------

// File: rtl/filter_buffer_5x5.sv
// filter_buffer_5x5
//   Weight store for the convolution datapath: FILTER_DEPTH slots of N x N
//   signed DATA_W-bit filters plus a BIAS_DEPTH-entry bias vector.
//   Ports:
//     clk, reset (async, active-low)
//     FB_write, FB_bias_or_filter (1 = filter store, 0 = bias store)
//     FB_filter [row][col], FB_index_filter : filter write data / slot
//     FB_bias [k]                         : whole bias vector write data
//     FB_index_bias                       : bias read index
//     index_filter                        : filter read slot
//     filter, FB_output_bias              : registered read data (1-cycle)
//     FB_filter_buffer_finish             : 1 after an edge with an accepted write
module filter_buffer_5x5 #(
  parameter int N            = 5,
  parameter int DATA_W       = 16,
  parameter int FILTER_DEPTH = 300,
  parameter int BIAS_DEPTH   = 120
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 FB_write,
  input  logic                                 FB_bias_or_filter,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]      FB_filter,
  input  logic [15:0]                          FB_index_filter,
  input  logic [BIAS_DEPTH-1:0][DATA_W-1:0]    FB_bias,
  input  logic [15:0]                          FB_index_bias,
  input  logic [15:0]                          index_filter,
  output logic [N-1:0][N-1:0][DATA_W-1:0]      filter,
  output logic [DATA_W-1:0]                    FB_output_bias,
  output logic                                 FB_filter_buffer_finish
);

  typedef logic [N-1:0][N-1:0][DATA_W-1:0] filt_t;

  // Indices are unsigned 16-bit; "negative" values land above the depth,
  // so one unsigned compare covers both out-of-range cases.
  localparam logic [15:0] FDEP = 16'(FILTER_DEPTH);

  filt_t                            r_filt [FILTER_DEPTH];
  logic [BIAS_DEPTH-1:0][DATA_W-1:0] r_bias;

  logic  w_fwr, w_bwr;
  filt_t w_frd;
  logic [DATA_W-1:0] w_brd;

  assign w_fwr = FB_write &  FB_bias_or_filter & (FB_index_filter < FDEP);
  assign w_bwr = FB_write & ~FB_bias_or_filter;

  // Storage: slot-select by compare rather than array index so the full
  // 16-bit index takes part and out-of-range slots simply never match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < FILTER_DEPTH; s++) r_filt[s] <= '0;
      r_bias <= '0;
    end else begin
      for (int s = 0; s < FILTER_DEPTH; s++)
        if (w_fwr && FB_index_filter == 16'(s)) r_filt[s] <= FB_filter;
      if (w_bwr) r_bias <= FB_bias;
    end
  end

  // Read muxes with write-first bypass; no match means zero.
  always_comb begin
    w_frd = '0;
    for (int s = 0; s < FILTER_DEPTH; s++)
      if (index_filter == 16'(s)) w_frd = r_filt[s];
    if (w_fwr && FB_index_filter == index_filter) w_frd = FB_filter;
  end

  always_comb begin
    w_brd = '0;
    for (int k = 0; k < BIAS_DEPTH; k++)
      if (FB_index_bias == 16'(k)) w_brd = w_bwr ? FB_bias[k] : r_bias[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter                  <= '0;
      FB_output_bias          <= '0;
      FB_filter_buffer_finish <= 1'b0;
    end else begin
      filter                  <= w_frd;
      FB_output_bias          <= w_brd;
      FB_filter_buffer_finish <= w_fwr | w_bwr;
    end
  end

endmodule

// File: tb/tb_filter_buffer_5x5.sv
module tb_filter_buffer_5x5;
  localparam int N = 5, DW = 16, FD = 300, BD = 120;
  typedef logic [N-1:0][N-1:0][DW-1:0] filt_t;

  logic clk = 1'b0;
  logic reset, FB_write, FB_bias_or_filter;
  filt_t FB_filter, filter;
  logic [15:0] FB_index_filter, FB_index_bias, index_filter;
  logic [BD-1:0][DW-1:0] FB_bias;
  logic [DW-1:0] FB_output_bias;
  logic FB_filter_buffer_finish;

  always #5 clk = ~clk;

  filter_buffer_5x5 #(.N(N), .DATA_W(DW), .FILTER_DEPTH(FD), .BIAS_DEPTH(BD)) dut (
    .clk(clk), .reset(reset), .FB_write(FB_write), .FB_bias_or_filter(FB_bias_or_filter),
    .FB_filter(FB_filter), .FB_index_filter(FB_index_filter), .FB_bias(FB_bias),
    .FB_index_bias(FB_index_bias), .index_filter(index_filter), .filter(filter),
    .FB_output_bias(FB_output_bias), .FB_filter_buffer_finish(FB_filter_buffer_finish));

  typedef struct { string name; filt_t f; logic [DW-1:0] b; logic fin; } exp_t;
  exp_t sbq[$];

  typedef struct {
    string name; logic wr; logic sel; logic [15:0] widx; logic [15:0] ridx; logic [15:0] bidx;
    logic [DW-1:0] exp_b; logic exp_fin; logic exp_fzero;
  } vec_t;

  filt_t m_filt [FD];
  logic [BD-1:0][DW-1:0] m_bias;
  int checks = 0, failures = 0;

  task automatic cmp(input string n, input logic [399:0] act, input logic [399:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic filt_t rnd_filt();
    filt_t t;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) t[r][c] = 16'($urandom_range(99, 0));
    return t;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < FD; s++) m_filt[s] = '0;
    m_bias = '0;
  endtask

  // Drive one edge: compute expected response from the model, push it,
  // clock, then pop and compare against the registered outputs.
  task automatic step(input string name, input logic wr, input logic sel,
                      input logic [15:0] widx, input logic [15:0] ridx,
                      input logic [15:0] bidx, input filt_t d);
    exp_t e, g;
    FB_write = wr; FB_bias_or_filter = sel; FB_index_filter = widx;
    index_filter = ridx; FB_index_bias = bidx; FB_filter = d;
    e.name = name;
    e.fin  = wr && (!sel || int'(widx) < FD);
    if (int'(ridx) < FD) e.f = (wr && sel && widx == ridx) ? d : m_filt[ridx[8:0]];
    else                 e.f = '0;
    if (int'(bidx) < BD) e.b = (wr && !sel) ? FB_bias[bidx[6:0]] : m_bias[bidx[6:0]];
    else                 e.b = '0;
    if (wr && sel && int'(widx) < FD) m_filt[widx[8:0]] = d;
    if (wr && !sel) m_bias = FB_bias;
    sbq.push_back(e);
    @(posedge clk); #1;
    g = sbq.pop_front();
    cmp({g.name, "_filter"}, filter, g.f);
    cmp({g.name, "_bias"}, FB_output_bias, g.b);
    cmp({g.name, "_finish"}, FB_filter_buffer_finish, g.fin);
  endtask

  vec_t tbl [10];
  filt_t d, d10, d11;

  initial begin
    // Vectors applied after the sweep; bias is 0 until the load in entry 6.
    tbl[0] = '{"rd0",    0, 1, 0,       0,       0,       16'd0,     0, 0};
    tbl[1] = '{"rd150",  0, 1, 0,       150,     0,       16'd0,     0, 0};
    tbl[2] = '{"rd299",  0, 1, 0,       299,     0,       16'd0,     0, 0};
    tbl[3] = '{"rd300",  0, 1, 0,       300,     0,       16'd0,     0, 1};
    tbl[4] = '{"wr300",  1, 1, 300,     300,     0,       16'd0,     0, 1};
    tbl[5] = '{"wrneg",  1, 1, 16'hFFFF, 16'hFFFF, 0,     16'd0,     0, 1};
    tbl[6] = '{"bload",  1, 0, 0,       5,       0,       16'hFFC4,  1, 0};
    tbl[7] = '{"b119",   0, 1, 0,       150,     119,     16'd59,    0, 0};
    tbl[8] = '{"b120",   0, 1, 0,       0,       120,     16'd0,     0, 0};
    tbl[9] = '{"bneg",   0, 1, 0,       299,     16'hFFFF, 16'd0,    0, 0};

    clear_model();
    reset = 1'b0; FB_write = 0; FB_bias_or_filter = 0; FB_filter = '0;
    FB_index_filter = 0; FB_index_bias = 0; index_filter = 0; FB_bias = '0;

    repeat (2) @(posedge clk);
    #1;
    cmp("rst_filter", filter, '0);
    cmp("rst_bias", FB_output_bias, '0);
    cmp("rst_finish", FB_filter_buffer_finish, 1'b0);
    reset = 1'b1;
    step("rel_rd7", 0, 1, 0, 7, 0, '0);

    // Sweep every slot with write-and-read of the same index.
    for (int i = 0; i < FD; i++) begin
      d = rnd_filt();
      step("sweep", 1, 1, 16'(i), 16'(i), 0, d);
    end
    step("sweep_idle", 0, 1, 0, 299, 0, '0);

    for (int k = 0; k < BD; k++) FB_bias[k] = 16'(k - 60);

    foreach (tbl[i]) begin
      step(tbl[i].name, tbl[i].wr, tbl[i].sel, tbl[i].widx, tbl[i].ridx, tbl[i].bidx, rnd_filt());
      cmp({tbl[i].name, "_tb_bias"}, FB_output_bias, tbl[i].exp_b);
      cmp({tbl[i].name, "_tb_fin"}, FB_filter_buffer_finish, tbl[i].exp_fin);
      if (tbl[i].exp_fzero) cmp({tbl[i].name, "_tb_zero"}, filter, '0);
    end

    // Extreme signed values survive storage untouched.
    d = rnd_filt();
    d[0][0] = 16'h8000; d[4][4] = 16'h7FFF;
    step("neg_wr", 1, 1, 5, 5, 0, d);
    step("neg_rd", 0, 1, 0, 5, 0, '0);
    cmp("neg_00", filter[0][0], 16'h8000);
    cmp("neg_44", filter[4][4], 16'h7FFF);

    // Back-to-back writes, then an asynchronous reset mid-cycle.
    d10 = rnd_filt(); d11 = rnd_filt();
    step("b2b_w10", 1, 1, 10, 10, 119, d10);
    step("b2b_w11", 1, 1, 11, 10, 119, d11);
    #2 reset = 1'b0;
    #1;
    cmp("arst_finish", FB_filter_buffer_finish, 1'b0);
    cmp("arst_filter", filter, '0);
    cmp("arst_bias", FB_output_bias, '0);
    clear_model();
    FB_write = 1; FB_bias_or_filter = 1; FB_index_filter = 12; FB_filter = d10;
    @(posedge clk); #1;
    cmp("arst_wr_finish", FB_filter_buffer_finish, 1'b0);
    FB_write = 0;
    reset = 1'b1;
    step("post_rd10", 0, 1, 0, 10, 119, '0);
    step("post_rd12", 0, 1, 0, 12, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
